// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in / serial-out serializer.
// The PARITY state is only reachable when PISO_PARITY_EN is defined.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with back-to-back frame support.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync_clr,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sd_out,
  output logic             sd_valid,
  output logic             sd_first
);

  localparam int                CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sd_out;
  logic               r_sd_valid;
  logic               r_sd_first;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_sd_out_nxt;
  logic               w_last_bit;
  logic               w_last_cycle;
  logic               w_accept;

`ifdef PISO_PARITY_EN
  logic               r_par;
  logic               w_par_nxt;
`endif

  // Bit currently at the head of the shift register in transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
  assign w_last_cycle = (r_state == PARITY);
`else
  assign w_last_cycle = w_last_bit;
`endif

  // Ready in IDLE or on the final frame cycle so frames can abut without a gap.
  assign load_ready = rst_n & ~sync_clr & ((r_state == IDLE) | w_last_cycle);
  assign w_accept   = load_valid & load_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
`ifdef PISO_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (sync_clr) begin
      w_state_nxt = IDLE;
      w_shift_nxt = '0;
      w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
      w_par_nxt   = 1'b0;
`endif
    end else if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = load_data;
      w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
      w_par_nxt   = ^load_data;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          if (w_last_bit) begin
            w_cnt_nxt = '0;
`ifdef PISO_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = IDLE;
`endif
          end else begin
            w_shift_nxt = shift_one(r_shift);
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_sd_out_nxt = 1'b0;
    case (w_state_nxt)
      SHIFT:   w_sd_out_nxt = head_bit(w_shift_nxt);
`ifdef PISO_PARITY_EN
      PARITY:  w_sd_out_nxt = w_par_nxt;
`endif
      default: w_sd_out_nxt = 1'b0;
    endcase
  end

  // Serial outputs are registered from next-state values: no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sd_out   <= 1'b0;
      r_sd_valid <= 1'b0;
      r_sd_first <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sd_out   <= w_sd_out_nxt;
      r_sd_valid <= (w_state_nxt != IDLE);
      r_sd_first <= (w_state_nxt == SHIFT) && (w_cnt_nxt == '0);
`ifdef PISO_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign sd_out   = r_sd_out;
  assign sd_valid = r_sd_valid;
  assign sd_first = r_sd_first;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances share stimulus
// and are compared each cycle against a queue-of-frame-bits reference model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sync_clr = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         rdy0, rdy1, so0, so1, sv0, sv1, sf0, sf1;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .load_valid(load_valid),
    .load_data(load_data), .load_ready(rdy0), .sd_out(so0), .sd_valid(sv0), .sd_first(sf0)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .load_valid(load_valid),
    .load_data(load_data), .load_ready(rdy1), .sd_out(so1), .sd_valid(sv1), .sd_first(sf1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic f;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] rec0 = '0;
  logic [63:0] rec1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame: the word's bits in transmit order, then parity when enabled.
  task automatic push_frame(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      q0.push_back('{b: d[W-1-i], f: (i == 0)});
      q1.push_back('{b: d[i],     f: (i == 0)});
    end
`ifdef PISO_PARITY_EN
    q0.push_back('{b: ^d, f: 1'b0});
    q1.push_back('{b: ^d, f: 1'b0});
`endif
  endtask

  task automatic check_outputs();
    ent_t e0, e1;
    e0 = '0;
    e1 = '0;
    if (q0.size() > 0) e0 = q0[0];
    if (q1.size() > 0) e1 = q1[0];
    chk("msb_valid", sv0, q0.size() > 0);
    chk("msb_out",   so0, e0.b);
    chk("msb_first", sf0, e0.f);
    chk("lsb_valid", sv1, q1.size() > 0);
    chk("lsb_out",   so1, e1.b);
    chk("lsb_first", sf1, e1.f);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic lv, input logic [W-1:0] d, input logic clr);
    logic exp_rdy;
    logic acc;
    load_valid = lv;
    load_data  = d;
    sync_clr   = clr;
    #1;
    exp_rdy = rst_n && !clr && (q0.size() <= 1);
    chk("msb_load_ready", rdy0, exp_rdy);
    chk("lsb_load_ready", rdy1, exp_rdy);
    check_outputs();
    if (sv0) rec0 = {rec0[62:0], so0};
    if (sv1) rec1 = {rec1[62:0], so1};
    acc = lv && exp_rdy;
    @(posedge clk);
    if (!rst_n || clr) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc) push_frame(d);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * FL && q0.size() > 0; n++) step(1'b0, W'($urandom), 1'b0);
    step(1'b0, W'($urandom), 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Held in reset: outputs quiet, not ready, word not taken.
    step(1'b1, 8'hA5, 1'b0);
    rst_n = 1'b1;

    // A5 accepted on the first edge after release.
    rec0 = '0;
    rec1 = '0;
    step(1'b1, 8'hA5, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    chk("a5_msb_stream", rec0[8:0], {8'hA5, 1'b0});
`else
    chk("a5_msb_stream", rec0[7:0], 8'hA5);
`endif

    // 01 then 80 back-to-back; 80 is held on load_data mid-frame until taken.
    rec0 = '0;
    rec1 = '0;
    step(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < FL; i++) step(1'b1, 8'h80, 1'b0);
    drain();
`ifdef PISO_PARITY_EN
    chk("b2b_lsb_stream", rec1[17:0], 18'b100000001000000011);
`else
    chk("b2b_lsb_stream", rec1[15:0], 16'h8001);
`endif

    // sync_clr with load_valid during bit 3 of FF.
    step(1'b1, 8'hFF, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    // Asynchronous reset during bit 5 of 3C.
    step(1'b1, 8'h3C, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    #2;
    chk("pre_reset_valid", sv0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", sv0, 1'b0);
    chk("async_rst_first", sf0, 1'b0);
    chk("async_rst_out",   so0, 1'b0);
    chk("async_rst_valid_lsb", sv1, 1'b0);
    chk("async_rst_ready", rdy0, 1'b0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    step(1'b1, 8'hC3, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 8'h96, 1'b0);
    drain();

    // Randomized traffic with occasional synchronous clears.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 29) == 0);
    drain();

`ifdef PISO_PARITY_EN
    rec0 = '0;
    step(1'b1, 8'h07, 1'b0);
    drain();
    chk("par07_stream", rec0[8:0], 9'b000001111);
    rec0 = '0;
    step(1'b1, 8'h03, 1'b0);
    drain();
    chk("par03_stream", rec0[8:0], 9'b000000110);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sync_clr  input  1  synchronous clear, sampled on rising clk.
REQ-006 load_valid  input  1  load_data holds a word to send.
REQ-007 load_data  input  WIDTH  parallel word.
REQ-008 load_ready  output  1  block can accept a word this cycle.
REQ-009 sd_out  output  1  serial data bit.
REQ-010 sd_valid  output  1  sd_out carries a frame bit this cycle.
REQ-011 sd_first  output  1  high on the first bit of each frame only.

Function
REQ-012 States SHALL be IDLE, SHIFT and PARITY. PARITY exists only when PISO_PARITY_EN is defined.
REQ-013 A word SHALL be accepted on a rising edge where load_valid=1, load_ready=1 and sync_clr=0.
- The word is captured into the shift register.
- The bit counter is set to 0.
- The next state is SHIFT.
REQ-014 Latency: bit 0 of the frame SHALL appear on sd_out, with sd_valid=1 and sd_first=1, in the cycle after the accepting edge.
REQ-015 In SHIFT, the block SHALL present one bit per cycle, in MSB_FIRST order, for exactly WIDTH cycles.
- The counter increments modulo WIDTH.
- The counter wraps to 0 on the final bit.
REQ-016 After the final data bit, the next state SHALL be PARITY if the macro is defined; otherwise IDLE.
REQ-017 load_ready SHALL be asserted when sync_clr=0 and either:
- the state is IDLE, or
- the current cycle is the last frame cycle (last data bit, or the PARITY cycle).
REQ-018 A word accepted on the last frame cycle SHALL start a new frame in the next cycle, with no idle gap between frames.
REQ-019 sd_out, sd_valid and sd_first SHALL depend only on registered state, never combinationally on inputs.
REQ-020 In IDLE, the outputs SHALL be sd_out=0, sd_valid=0 and sd_first=0.
REQ-021 If sync_clr=1 on an edge, the block SHALL:
- go to IDLE, clear the shift register and the counter;
- abandon the current frame;
- not accept a word that edge, even if load_valid=1.
REQ-022 load_data SHALL be ignored outside accepting edges; changing it mid-frame SHALL NOT change the bits being sent.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- shift register, counter and parity register to 0;
- sd_out=0, sd_valid=0, sd_first=0.
REQ-024 While rst_n=0, load_ready SHALL be 0.
REQ-025 Reset deassertion SHALL take effect on the next rising clk. The first word can be accepted on that edge.
REQ-026 Reset mid-frame SHALL discard the frame; no partial bits are emitted after reset.

Configuration
REQ-027 Macro PISO_PARITY_EN.
- When defined: each frame SHALL be WIDTH+1 cycles. The final cycle is the PARITY state, with sd_out = XOR of all bits of the accepted word (even parity), sd_valid=1 and sd_first=0.
- When undefined: each frame SHALL be exactly WIDTH cycles, with no parity register and no PARITY state.

Structure
REQ-028 Shared package piso_pkg SHALL hold:
- the state enum type (IDLE, SHIFT, PARITY);
- the WIDTH default constant;
- the counter width function (clog2 of WIDTH).
REQ-029 There SHALL be no sub-module. The shifter, counter and FSM are inline; a separate module is not natural at this size.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, accept 8'hA5 at edge 0 -> sd_out = 1,0,1,0,0,1,0,1 over cycles 1-8. sd_valid=1 on cycles 1-8, sd_first=1 on cycle 1 only, sd_valid=0 on cycle 9.
REQ-031 MSB_FIRST=0, 8'h01 then 8'h80 presented back-to-back -> 16 contiguous sd_valid cycles. Stream is 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, with sd_first on cycles 1 and 9.
REQ-032 8'hFF accepted, sync_clr=1 together with load_valid=1 during bit 3 -> sd_valid=0 the next cycle, no word accepted, load_ready=1 once sync_clr=0.
REQ-033 rst_n pulsed low during bit 5 of 8'h3C -> outputs drop to 0 without a clock edge, load_ready=0 while low, new word accepted on the first edge after release.
REQ-034 With PISO_PARITY_EN, 8'h07 -> 9 valid cycles, ninth sd_out=1. 8'h03 -> ninth sd_out=0. load_ready=1 only in IDLE and on the ninth cycle.
